// File: rtl/fast_timer_n.sv
// fast_timer_n
//   Reloadable down-counter timer. Produces a registered one-cycle `tick`
//   every R+1 enabled cycles, either once (one-shot) or repeatedly
//   (periodic). `tick` is intended as the clock enable for downstream
//   register banks.
//
// Parameters
//   WIDTH       counter / reload register width (2..24)
//   RBEL_X      placement column of the count datapath
//   RBEL_Y      placement base row
//   RBEL_Z      placement base slot within the row
//   RBEL_GROUP  placement group name shared by all datapath cells
//
// Ports
//   clk       in   clock, single domain
//   rst       in   synchronous active-high reset
//   load_val  in   value written to the reload register
//   load      in   strobe: capture load_val into R (and C when idle)
//   start     in   strobe: (re)start counting from R
//   stop      in   strobe: halt counting, hold count
//   periodic  in   level: 1 = auto-reload at terminal count, 0 = one-shot
//   en        in   count enable (prescaler input)
//   cnt       out  current count value C
//   tick      out  registered one-cycle terminal-count pulse
//   busy      out  run flag
module fast_timer_n #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned RBEL_X     = 0,
  parameter int unsigned RBEL_Y     = 0,
  parameter int unsigned RBEL_Z     = 0,
  parameter              RBEL_GROUP = ""
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_val,
  input  logic             load,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             tick,
  output logic             busy
);

  // Elaboration-time sanity checks on the configuration.
  generate
    if (WIDTH < 2 || WIDTH > 24) begin : g_bad_width
      $error("fast_timer_n: WIDTH must be in 2..24");
    end
    if (RBEL_Z > 7) begin : g_bad_slot
      $error("fast_timer_n: RBEL_Z must address a slot 0..7");
    end
    if (RBEL_X > 255 || RBEL_Y > 255) begin : g_bad_xy
      $error("fast_timer_n: RBEL_X/RBEL_Y outside the fabric grid");
    end
    if ($bits(RBEL_GROUP) > 8 * 64) begin : g_bad_group
      $error("fast_timer_n: RBEL_GROUP name too long");
    end
  endgenerate

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] c_q;
  logic             run_q;
  logic             tick_q;

  // Decrement and zero detect share one carry chain: C + all-ones with
  // carry-in 0 gives C-1, and the carry-out is 0 exactly when C == 0.
  logic [WIDTH:0]   chain;
  logic [WIDTH-1:0] c_dec;
  logic             c_nz;

  always_comb begin
    chain = {1'b0, c_q} + {1'b0, {WIDTH{1'b1}}};
    c_dec = chain[WIDTH-1:0];
    c_nz  = chain[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      c_q    <= '0;
      run_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (load) begin
        r_q <= load_val;
      end

      if (stop) begin
        // stop wins over start; an idle timer still follows load.
        run_q <= 1'b0;
        if (load && !run_q) begin
          c_q <= load_val;
        end
      end else if (start) begin
        run_q <= 1'b1;
        c_q   <= load ? load_val : r_q;
      end else if (run_q) begin
        // While running, load only touches R; C picks it up on reload.
        if (en) begin
          if (c_nz) begin
            c_q <= c_dec;
          end else begin
            tick_q <= 1'b1;
            if (periodic) begin
              c_q <= r_q;
            end else begin
              run_q <= 1'b0;
            end
          end
        end
      end else if (load) begin
        c_q <= load_val;
      end
    end
  end

  assign cnt  = c_q;
  assign tick = tick_q;
  assign busy = run_q;

endmodule

// File: doc/fast_timer_n.md
# fast_timer_n

Hard-placed, reloadable down-counter timer for iCE40 built from the carry-chain and flip-flop primitive wrappers (`lut4_carry_n`, `dffesr_n`). It generates a single-cycle `tick` every `R+1` enabled cycles, in one-shot or periodic mode. `tick` is the clock-enable source for downstream `dffe_n` / `dffesr_n` register banks. Placement attributes pin the count datapath to a fixed column, giving deterministic timing at full fabric clock rate.

## Interface
- `WIDTH`, 16, counter and reload register width (2..24)
- `RBEL_X`, 0, placement column of the datapath
- `RBEL_Y`, 0, placement base row
- `RBEL_Z`, 0, placement base slot within the row
- `RBEL_GROUP`, "", placement group name, passed to all primitives

- `clk`  in  1  clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `load_val`  in  WIDTH  value written to the reload register
- `load`  in  1  strobe; capture `load_val`
- `start`  in  1  strobe; (re)start counting from the reload register
- `stop`  in  1  strobe; halt counting, hold count
- `periodic`  in  1  level; 1 = auto-reload at terminal count, 0 = one-shot
- `en`  in  1  count enable (prescaler input); counting advances only when high
- `cnt`  out  WIDTH  current count value C
- `tick`  out  1  registered one-cycle terminal-count pulse
- `busy`  out  1  run flag

## Operation
- State:
  - reload register R (`dffesr_n`, RSTVAL 0);
  - count register C (`dffesr_n`, RSTVAL 0);
  - run flag;
  - tick flop.
- Decrement and zero detect share one `lut4_carry_n` chain:
  - computes C + all-ones, cin=0;
  - `cout`=0 iff C==0;
  - no separate comparator.
- Reset (`rst`=1 at an edge): R=0, C=0, `busy`=0, `tick`=0. Reset overrides every other input, including mid-count.
- Priority per edge, highest first: `rst`, `stop`, `start`, count step. `load` is independent of this ordering.
- `load`:
  - R <= `load_val`.
  - If not running and no `start` in the same cycle, C <= `load_val` too.
  - If running, only R changes; the new value takes effect at the next reload or restart.
- `start`:
  - run <= 1 and C <= R.
  - If `load` is in the same cycle, C <= `load_val` (the new value).
  - `start` while running restarts the count.
- `stop`: run <= 0, C held. `stop` together with `start` leaves the timer stopped.
- Count step, applied when run=1, `en`=1, no `stop`/`start`:
  - C != 0: C <= C-1.
  - C == 0, `periodic`=1: `tick` <= 1, C <= R, run stays 1.
  - C == 0, `periodic`=0: `tick` <= 1, run <= 0, C stays 0.
- `tick` <= 0 on every edge not covered above.
- `en`=0 freezes C; no tick is generated.
- `periodic` is sampled only at terminal count. Changing it mid-count is legal.
- Arithmetic is unsigned modulo 2^WIDTH. C never wraps below 0, because the C==0 case always reloads or stops.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Start to first tick, with `en` constantly 1:
  - `start` sampled at edge t gives C=R after edge t;
  - `tick` is high in the cycle after edge t+R+1.
- Periodic mode, `en` constantly 1: `tick` period is exactly R+1 cycles. R=0 gives `tick` high every cycle.
- With `en` gated, the period is R+1 enabled cycles.
- `busy` falls on the same edge that raises the one-shot `tick`.
- `cnt` reflects C directly, with zero latency from the register.
- Critical path is one WIDTH-bit carry chain plus a LUT mux; target is full fabric Fmax for WIDTH ≤ 24.

## Test plan
- Reset mid-count:
  - run periodic with R=100;
  - assert `rst` at C=37;
  - next cycle: C=0, R=0, `busy`=0, `tick`=0;
  - no tick afterwards without a new `start`.
- Periodic, R=4, `en`=1:
  - `load` 4 then `start`;
  - `tick` every 5 cycles, first tick 5 cycles after the start edge;
  - `cnt` sequence 4,3,2,1,0,4…
- One-shot, R=3:
  - `start`;
  - a single `tick` 4 cycles later, `busy` falls on the same edge;
  - `cnt` stays 0 with no further ticks over 20 cycles.
- Prescale, R=2, `en` high 1 cycle in 3:
  - `tick` every 9 cycles;
  - C changes only on cycles after `en`=1.
- Load while running:
  - R=9 periodic; `load` 2 at C=5;
  - current period completes (C counts to 0, tick);
  - subsequent periods are 3 cycles.
- Simultaneous events:
  - `start`+`stop` → `busy`=0;
  - `start`+`load` 7 → C=7 next cycle;
  - R=0 periodic → `tick` continuously high.
